// File: rtl/branch_stall_ctrl.sv
// Stall/flush controller for branches resolved in ID, plus load-use stalls.
// Stall outputs are combinational; a two-state FSM extends load-to-branch stalls.
module branch_stall_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_branch,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] if2id_rs,
  input  logic [REG_W-1:0] if2id_rt,
  input  logic             id2ex_regWrite,
  input  logic             id2ex_memRead,
  input  logic [REG_W-1:0] id2ex_writeReg,
  input  logic             ex2mem_memRead,
  input  logic [REG_W-1:0] ex2mem_writeReg,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if2id_write,
  output logic             id2ex_bubble,
  output logic             if2id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e state_q, state_d;

  logic use_rs;
  logic use_rt;
  logic ex_match;
  logic mem_match;
  logic h1;
  logic h2;
  logic stall;
  logic flush;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] cnt_one;

  assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Branches compare both operands in ID, so both are always treated as read.
  assign use_rs = id_branch | id_uses_rs;
  assign use_rt = id_branch | id_uses_rt;

  assign ex_match = (id2ex_writeReg != '0) &&
                    ((use_rs && (id2ex_writeReg == if2id_rs)) ||
                     (use_rt && (id2ex_writeReg == if2id_rt)));

  assign mem_match = (ex2mem_writeReg != '0) &&
                     ((use_rs && (ex2mem_writeReg == if2id_rs)) ||
                      (use_rt && (ex2mem_writeReg == if2id_rt)));

  assign h2 = id_branch && id2ex_memRead && ex_match;

  assign h1 = (id_branch && id2ex_regWrite && !id2ex_memRead && ex_match) ||
              (id_branch && ex2mem_memRead && mem_match) ||
              (!id_branch && id2ex_memRead && ex_match);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (h2) begin
          stall   = 1'b1;
          state_d = StHold;
        end else if (h1) begin
          stall   = 1'b1;
        end
      end
      StHold: begin
        // Load data is still one stage away from forwarding; inputs are ignored.
        stall   = 1'b1;
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Comparator result is stale while stalled, so the flush waits for resolution.
  assign flush = id_branch && branch_taken && !stall;

  always_comb begin
    pc_write     = 1'b1;
    if2id_write  = 1'b1;
    id2ex_bubble = 1'b0;
    if2id_flush  = 1'b0;
    if (!rst) begin
      pc_write     = !stall;
      if2id_write  = !stall;
      id2ex_bubble = stall;
      if2id_flush  = flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + cnt_one;
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + cnt_one;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
